// File: rtl/tt_sweep_ctrl.sv
// Code/channel sweep sequencer: settles the device at each drive code, strobes a sample,
// then steps the code per enabled channel. Define SWEEP_BIDIR_EN for an up-then-down sweep.
module tt_sweep_ctrl #(
    parameter int CODE_W     = 8,
    parameter int N_CH       = 4,
    parameter int SETTLE_CYC = 4,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CODE_W-1:0] step,
    input  logic [CODE_W-1:0] code_max,
    input  logic [N_CH-1:0]   ch_mask,
    output logic [CODE_W-1:0] code,
    output logic [CH_W-1:0]   ch_sel,
    output logic              drive_en,
    output logic              sample,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SAMPLE, S_ADVANCE, S_DONE
    } state_t;

    state_t            state_reg;
    logic [CODE_W-1:0] code_reg;
    logic [CH_W-1:0]   ch_reg;
    logic [CODE_W-1:0] step_reg;
    logic [CODE_W-1:0] max_reg;
    logic [N_CH-1:0]   mask_reg;
    logic [7:0]        cnt_reg;
    logic              drive_reg;
    logic              sample_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              first_found;
    logic [CH_W-1:0]   first_ch;
    logic              next_found;
    logic [CH_W-1:0]   next_ch;
    logic [CODE_W:0]   sum;
    logic [CODE_W-1:0] adv_code;
    logic              adv_end;
`ifdef SWEEP_BIDIR_EN
    logic              down_reg;
    logic              adv_down;
    logic [CODE_W-1:0] diff;
`endif

    // Lowest enabled channel of the live mask, and next higher enabled channel of the latched one
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(i);
            end
            if (mask_reg[i] && (i > int'(ch_reg))) begin
                next_found = 1'b1;
                next_ch    = CH_W'(i);
            end
        end
    end

    // Sum is one bit wider so an overflowing step ends the channel instead of wrapping
    always_comb begin
        sum      = {1'b0, code_reg} + {1'b0, step_reg};
        adv_code = sum[CODE_W-1:0];
        adv_end  = 1'b0;
`ifdef SWEEP_BIDIR_EN
        diff     = (code_reg > step_reg) ? (code_reg - step_reg) : '0;
        adv_down = down_reg;
        if (!down_reg && (sum <= {1'b0, max_reg})) begin
            adv_code = sum[CODE_W-1:0];
        end else if (code_reg != '0) begin
            adv_code = diff;
            adv_down = 1'b1;
        end else begin
            adv_end  = 1'b1;
        end
`else
        if (sum > {1'b0, max_reg})
            adv_end = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            code_reg   <= '0;
            ch_reg     <= '0;
            step_reg   <= '0;
            max_reg    <= '0;
            mask_reg   <= '0;
            cnt_reg    <= '0;
            drive_reg  <= 1'b0;
            sample_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef SWEEP_BIDIR_EN
            down_reg   <= 1'b0;
`endif
        end else if (abort) begin
            state_reg  <= S_IDLE;
            code_reg   <= '0;
            ch_reg     <= '0;
            cnt_reg    <= '0;
            drive_reg  <= 1'b0;
            sample_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef SWEEP_BIDIR_EN
            down_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        step_reg <= (step == '0) ? CODE_W'(1) : step;
                        max_reg  <= code_max;
                        mask_reg <= ch_mask;
                        code_reg <= '0;
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
                        if (first_found) begin
                            ch_reg    <= first_ch;
                            drive_reg <= 1'b1;
                            state_reg <= S_SETTLE;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_reg == 8'(SETTLE_CYC - 1)) begin
                        sample_reg <= 1'b1;
                        state_reg  <= S_SAMPLE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                S_SAMPLE: begin
                    sample_reg <= 1'b0;
                    state_reg  <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    cnt_reg <= '0;
                    if (adv_end) begin
                        code_reg <= '0;
`ifdef SWEEP_BIDIR_EN
                        down_reg <= 1'b0;
`endif
                        if (next_found) begin
                            ch_reg    <= next_ch;
                            state_reg <= S_SETTLE;
                        end else begin
                            drive_reg <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end else begin
                        code_reg  <= adv_code;
`ifdef SWEEP_BIDIR_EN
                        down_reg  <= adv_down;
`endif
                        state_reg <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    code_reg  <= '0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Abort must kill the strobes within the very cycle it is raised
    assign sample   = sample_reg & ~abort;
    assign done     = done_reg & ~abort;
    assign code     = code_reg;
    assign ch_sel   = ch_reg;
    assign drive_en = drive_reg;
    assign busy     = busy_reg;

endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter CODE_W, default 8: width of the drive code (code, step, code_max).
REQ-002 SHALL have parameter N_CH, default 4 (range 1..8): number of device channels.
REQ-003 SHALL have parameter SETTLE_CYC, default 4 (range 1..255): number of drive cycles before each sample.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-007 SHALL have port abort  input  1  terminates any sweep in progress.
REQ-008 SHALL have port step  input  CODE_W  code increment; a value of 0 is treated as 1.
REQ-009 SHALL have port code_max  input  CODE_W  highest code allowed in a sweep.
REQ-010 SHALL have port ch_mask  input  N_CH  channel-enable mask; bit i enables channel i.
REQ-011 SHALL have port code  output  CODE_W  current drive code.
REQ-012 SHALL have port ch_sel  output  max(1,clog2(N_CH))  index of the active channel.
REQ-013 SHALL have port drive_en  output  1  device drive active.
REQ-014 SHALL have port sample  output  1  one-cycle capture strobe.
REQ-015 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal sweep completion.

Function
REQ-017 SHALL implement the states IDLE, SETTLE, SAMPLE, ADVANCE and DONE.
REQ-018 SHALL, in IDLE with start=1, latch step, code_max and ch_mask, set code=0 and ch_sel=lowest enabled channel, and enter SETTLE.
REQ-019 SHALL, when start is captured with ch_mask==0, go directly to DONE, with drive_en and sample never asserted.
REQ-020 SHALL hold drive_en=1 in SETTLE, SAMPLE and ADVANCE, and drive_en=0 in IDLE and DONE.
REQ-021 SHALL stay in SETTLE for exactly SETTLE_CYC cycles, then spend 1 cycle in SAMPLE with sample=1.
REQ-022 SHALL place the first sample pulse in cycle SETTLE_CYC+1 after the capturing edge, and SHALL hold code and ch_sel constant through SETTLE and SAMPLE.
REQ-023 SHALL, in ADVANCE (1 cycle), compute code+step in CODE_W+1 bits.
REQ-024 SHALL, if that sum is ≤ code_max, load it into code and return to SETTLE.
REQ-025 SHALL otherwise end the channel; a channel end with no higher enabled channel SHALL go to DONE.
REQ-026 SHALL, on a channel end with a higher enabled channel, select the next higher enabled channel, set code=0 and enter SETTLE.
REQ-027 SHALL never drive a code above code_max, and code SHALL never wrap.
REQ-028 SHALL, when code_max=0, produce exactly one sample per enabled channel, at code 0.
REQ-029 SHALL assert done for 1 cycle in DONE, then return to IDLE.
REQ-030 SHALL ignore start while busy=1, and SHALL ignore input changes after capture.
REQ-031 SHALL give abort priority over start and all transitions: the next state is IDLE, done is not asserted, and sample is suppressed in that cycle.
REQ-032 SHALL, on abort, clear code to 0, with drive_en=0 from the next cycle.

Reset
REQ-033 SHALL, while rst=1 (asynchronously), force state=IDLE, code=0, ch_sel=0, drive_en=0, sample=0, busy=0, done=0.
REQ-034 SHALL, on rst mid-sweep, discard all latched settings; after rst deasserts, the block SHALL need a fresh start.

Configuration
REQ-035 SHALL, with macro SWEEP_BIDIR_EN defined, after a channel's last ascending code, descend code by step, sampling each code, down to and including 0, then end the channel; the peak code SHALL not be resampled.
REQ-036 SHALL, on the descent, clamp any subtraction that would go below 0 to 0 (floor 0), and SHALL sample the clamped 0 once.
REQ-037 SHALL, with SWEEP_BIDIR_EN undefined, sweep ascending only, with no descent logic present.

Verification
REQ-038 SHALL cover: step=64, code_max=200, ch_mask=0001, SETTLE_CYC=4 -> samples at codes 0,64,128,192 on ch 0; first sample 5 cycles after start; done once; 4 samples total.
REQ-039 SHALL cover: ch_mask=1010, step=255, code_max=255 -> ch_sel 1 then 3; codes 0,255 on each channel; no code wrap.
REQ-040 SHALL cover: ch_mask=0000 -> busy for the DONE cycle only, done pulse, zero samples, drive_en never high.
REQ-041 SHALL cover: abort asserted in the SAMPLE cycle of the second step -> no sample that cycle, IDLE next, drive_en low, done never asserted; a second start during busy is ignored.
REQ-042 SHALL cover: rst pulsed mid-SETTLE -> all outputs go to reset values immediately, without waiting for a clock edge.
REQ-043 SHALL cover, with SWEEP_BIDIR_EN: step=100, code_max=250, 1 channel -> sample codes 0,100,200,100,0, then done.
